// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding and register-number width for the pipeline core
package cpu_pkg;
  localparam int REG_W = 5;
  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_stat_counter.sv
// stat_counter: wrapping event counter with asynchronous active-low clear
module stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  // count one per qualifying edge, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) count <= '0;
    else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/halt sequencing for PC, IF/ID and ID/EX plus statistics
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int REG_W = cpu_pkg::REG_W
) (
  input  logic             in_CLK,
  input  logic             in_CLR_N,
  input  logic [REG_W-1:0] in_id_rs,
  input  logic [REG_W-1:0] in_id_rt,
  input  logic             in_id_use_rs,
  input  logic             in_id_use_rt,
  input  logic             in_ex_memread,
  input  logic [REG_W-1:0] in_ex_rd,
  input  logic             in_ex_br_taken,
  input  logic             in_id_jump,
  input  logic             in_ex_halt,
  input  logic             in_go,
  output logic             out_pc_en,
  output logic             out_ifid_en,
  output logic             out_ifid_clr,
  output logic             out_idex_en,
  output logic             out_idex_clr,
  output logic             out_halted,
  output logic [CNT_W-1:0] out_cnt_cycle,
  output logic [CNT_W-1:0] out_cnt_stall,
  output logic [CNT_W-1:0] out_cnt_bflush,
  output logic [CNT_W-1:0] out_cnt_jflush
);
  import cpu_pkg::*;
  state_t state;
  logic run, lu, hlt, br, stall, jmp, resume;
  // decode hazards in priority order: halt > taken branch > load-use > jump
  always_comb begin
    run    = state == ST_RUN;
    lu     = in_ex_memread & (in_ex_rd != '0) &
             ((in_id_use_rs & (in_id_rs == in_ex_rd)) | (in_id_use_rt & (in_id_rt == in_ex_rd)));
    hlt    = run & in_ex_halt;
    br     = run & ~in_ex_halt & in_ex_br_taken;
    stall  = run & ~in_ex_halt & ~in_ex_br_taken & lu;
    jmp    = run & ~in_ex_halt & ~in_ex_br_taken & ~lu & in_id_jump;
    resume = ~run & in_go;
    out_pc_en    = (run & ~hlt & ~stall) | resume;
    out_ifid_en  = (run & ~hlt & ~stall) | resume;
    out_ifid_clr = br | jmp;
    out_idex_en  = (run & ~hlt) | resume;
    out_idex_clr = br | stall | resume;
    out_halted   = ~run;
  end
  // halt on a halt syscall in EX, resume on go; the exit cycle squashes the halt in ID/EX
  always_ff @(posedge in_CLK or negedge in_CLR_N)
    if (!in_CLR_N) state <= ST_RUN;
    else state <= run ? (in_ex_halt ? ST_HALT : ST_RUN) : (in_go ? ST_RUN : ST_HALT);
  stat_counter #(.CNT_W(CNT_W)) u_cycle  (.clk(in_CLK), .clr_n(in_CLR_N), .inc(run | resume), .count(out_cnt_cycle));
  stat_counter #(.CNT_W(CNT_W)) u_stall  (.clk(in_CLK), .clr_n(in_CLR_N), .inc(stall),        .count(out_cnt_stall));
  stat_counter #(.CNT_W(CNT_W)) u_bflush (.clk(in_CLK), .clr_n(in_CLR_N), .inc(br),           .count(out_cnt_bflush));
  stat_counter #(.CNT_W(CNT_W)) u_jflush (.clk(in_CLK), .clr_n(in_CLR_N), .inc(jmp),          .count(out_cnt_jflush));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for the hazard sequencer (CNT_W=4 to exercise wrap)
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;
  localparam int RW = 5;
  localparam logic [4:0] NORM = 5'b11010, STL = 5'b00011, BRF = 5'b11111,
                         JMPF = 5'b11110, HOUT = 5'b00000, RES = 5'b11011;
  typedef struct packed {
    logic [4:0]    ctrl;
    logic          halted;
    logic [CW-1:0] cyc, stl, bf, jf;
  } exp_t;

  logic clk = 0, rst_n = 0;
  logic [RW-1:0] id_rs = 0, id_rt = 0, ex_rd = 0;
  logic use_rs = 0, use_rt = 0, memread = 0, br_taken = 0, jump = 0, ex_halt = 0, go = 0;
  logic pc_en, ifid_en, ifid_clr, idex_en, idex_clr, halted;
  logic [CW-1:0] cnt_cycle, cnt_stall, cnt_bflush, cnt_jflush;
  logic [CW-1:0] m_cyc = 0, m_stl = 0, m_bf = 0, m_jf = 0;
  exp_t sb[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CW), .REG_W(RW)) dut (
    .in_CLK(clk), .in_CLR_N(rst_n), .in_id_rs(id_rs), .in_id_rt(id_rt),
    .in_id_use_rs(use_rs), .in_id_use_rt(use_rt), .in_ex_memread(memread),
    .in_ex_rd(ex_rd), .in_ex_br_taken(br_taken), .in_id_jump(jump),
    .in_ex_halt(ex_halt), .in_go(go), .out_pc_en(pc_en), .out_ifid_en(ifid_en),
    .out_ifid_clr(ifid_clr), .out_idex_en(idex_en), .out_idex_clr(idex_clr),
    .out_halted(halted), .out_cnt_cycle(cnt_cycle), .out_cnt_stall(cnt_stall),
    .out_cnt_bflush(cnt_bflush), .out_cnt_jflush(cnt_jflush));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [RW-1:0] rs, rt, rd, input logic urs, urt, mr, b, j, h, g);
    id_rs = rs; id_rt = rt; ex_rd = rd; use_rs = urs; use_rt = urt;
    memread = mr; br_taken = b; jump = j; ex_halt = h; go = g;
  endtask

  task automatic step(input string tag, input logic [4:0] ctrl, input logic hd,
                      input bit ci, si, bi, ji);
    logic [4:0] obs_ctrl;
    logic obs_halted;
    exp_t e;
    m_cyc += CW'(ci); m_stl += CW'(si); m_bf += CW'(bi); m_jf += CW'(ji);
    sb.push_back('{ctrl: ctrl, halted: hd, cyc: m_cyc, stl: m_stl, bf: m_bf, jf: m_jf});
    #2;
    obs_ctrl = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr};
    obs_halted = halted;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".ctrl"}, 32'(obs_ctrl), 32'(e.ctrl));
    chk({tag, ".halted"}, 32'(obs_halted), 32'(e.halted));
    chk({tag, ".cyc"}, 32'(cnt_cycle), 32'(e.cyc));
    chk({tag, ".stall"}, 32'(cnt_stall), 32'(e.stl));
    chk({tag, ".bflush"}, 32'(cnt_bflush), 32'(e.bf));
    chk({tag, ".jflush"}, 32'(cnt_jflush), 32'(e.jf));
    @(negedge clk);
  endtask

  initial begin
    logic [CW-1:0] before_wrap;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.halted", 32'(halted), 0);
    chk("reset.cyc", 32'(cnt_cycle), 0);
    chk("reset.stall", 32'(cnt_stall), 0);
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("normal", NORM, 0, 1, 0, 0, 0);
    drive(8, 0, 8, 1, 0, 1, 0, 0, 0, 0); step("lu_rs", STL, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("after_lu", NORM, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 0, 0, 0, 0); step("reg_zero", NORM, 0, 1, 0, 0, 0);
    drive(0, 3, 3, 0, 1, 1, 0, 0, 0, 0); step("lu_rt", STL, 0, 1, 1, 0, 0);
    drive(8, 0, 8, 0, 0, 1, 0, 0, 0, 0); step("no_use", NORM, 0, 1, 0, 0, 0);
    drive(8, 0, 8, 1, 0, 0, 0, 0, 0, 0); step("no_load", NORM, 0, 1, 0, 0, 0);
    drive(8, 0, 8, 1, 0, 1, 1, 0, 0, 0); step("br_vs_lu", BRF, 0, 1, 0, 1, 0);
    drive(8, 0, 8, 1, 0, 1, 0, 1, 0, 0); step("jmp_vs_lu", STL, 0, 1, 1, 0, 0);
    drive(8, 0, 8, 1, 0, 0, 0, 1, 0, 0); step("jmp", JMPF, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step("halt_entry", HOUT, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(8, 0, 8, 1, 0, 1, 1, 1, 1, 0); step("halted", HOUT, 1, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); step("resume", RES, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("post_resume", NORM, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step("go_in_run", NORM, 0, 1, 0, 0, 0);
    before_wrap = cnt_cycle;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("wrap", NORM, 0, 1, 0, 0, 0);
    end
    chk("wrap.cyc_return", 32'(cnt_cycle), 32'(before_wrap));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step("halt2_entry", HOUT, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("halt2", HOUT, 1, 0, 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    m_cyc = 0; m_stl = 0; m_bf = 0; m_jf = 0;
    chk("async_rst.halted", 32'(halted), 0);
    chk("async_rst.ctrl", 32'({pc_en, ifid_en, ifid_clr, idex_en, idex_clr}), 32'(NORM));
    chk("async_rst.cyc", 32'(cnt_cycle), 0);
    chk("async_rst.stall", 32'(cnt_stall), 0);
    chk("async_rst.bflush", 32'(cnt_bflush), 0);
    chk("async_rst.jflush", 32'(cnt_jflush), 0);
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("post_rst", NORM, 0, 1, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencer for the IF/ID and ID/EX pipeline registers and the PC of the 5-stage core.
- Generates per-stage enable/clear for load-use stalls, taken-branch flushes (resolved in EX), jump flushes (resolved in ID) and program halt/resume.
- Keeps cycle, stall and flush statistics counters for the front-panel display.

Parameters:
- CNT_W, 32, width of each statistics counter.
- REG_W, 5, register-number width.

Ports:
- in_CLK  input  1  system clock, rising edge.
- in_CLR_N  input  1  asynchronous active-low reset.
- in_id_rs  input  REG_W  rs field of instruction in ID.
- in_id_rt  input  REG_W  rt field of instruction in ID.
- in_id_use_rs  input  1  ID instruction reads rs.
- in_id_use_rt  input  1  ID instruction reads rt.
- in_ex_memread  input  1  instruction in EX is a load.
- in_ex_rd  input  REG_W  destination register of instruction in EX.
- in_ex_br_taken  input  1  branch in EX resolved taken.
- in_id_jump  input  1  unconditional jump decoded in ID.
- in_ex_halt  input  1  halt syscall in EX.
- in_go  input  1  resume request, level, sampled each edge.
- out_pc_en  output  1  PC load enable.
- out_ifid_en  output  1  IF/ID enable.
- out_ifid_clr  output  1  IF/ID clear.
- out_idex_en  output  1  ID/EX enable.
- out_idex_clr  output  1  ID/EX clear.
- out_halted  output  1  state is HALT.
- out_cnt_cycle  output  CNT_W  cycles spent in RUN.
- out_cnt_stall  output  CNT_W  load-use stall cycles.
- out_cnt_bflush  output  CNT_W  taken-branch flushes.
- out_cnt_jflush  output  CNT_W  jump flushes.

Behaviour:
- Reset (in_CLR_N=0, asynchronous): state RUN, all counters 0, out_halted=0.
- Control outputs are combinational from the inputs and state, sampled by the pipeline registers at the next rising edge.
- Clears are consumed synchronously: the integrating top gates them into the register EN path.
- States are RUN and HALT.
- Load-use hazard: lu = in_ex_memread & (in_ex_rd!=0) & ((in_id_use_rs & in_id_rs==in_ex_rd) | (in_id_use_rt & in_id_rt==in_ex_rd)).
- RUN priority, highest first:
  1. in_ex_halt: all enables 0, clears 0. Next state HALT.
  2. in_ex_br_taken: pc_en=1, ifid_en=1, ifid_clr=1, idex_en=1, idex_clr=1. bflush +1.
  3. lu: pc_en=0, ifid_en=0, idex_en=1, idex_clr=1, giving a one-bubble stall. stall +1. A simultaneous jump is deferred because pc_en=0.
  4. in_id_jump: pc_en=1, ifid_en=1, ifid_clr=1, idex_en=1, idex_clr=0. jflush +1.
  5. Otherwise all enables 1, clears 0.
- In RUN, cnt_cycle increments every edge, including the halt-entry edge.
- HALT:
  - All enables and clears are 0. out_halted=1. Counters frozen.
  - in_go=1: next state RUN. In that exit cycle, outputs are pc_en=1, ifid_en=1, idex_en=1, idex_clr=1, so the halt instruction is squashed and does not re-trigger.
  - The exit cycle is counted as a RUN cycle; cnt_cycle +1.
- in_go is ignored in RUN.
- Hazard and branch inputs are ignored in HALT.
- Counters wrap modulo 2^CNT_W, with no saturation.
- Reset asserted in HALT returns to RUN immediately and zeroes all counters.

Decomposition:
- Shared package (cpu_pkg): state encoding (ST_RUN=0, ST_HALT=1) and REG_W.
- One sub-module, stat_counter (CNT_W wide, inputs inc and async active-low clear), instantiated four times.
- Hazard and priority decode stays inline.

Test Plan:
- Load-use: ex memread=1, ex_rd=8, id_rs=8, use_rs=1 for one cycle -> pc_en=0, ifid_en=0, idex_clr=1 for exactly 1 cycle; cnt_stall=1.
- Reg zero: same as the load-use case but ex_rd=0 -> no stall; all enables 1; cnt_stall=0.
- Branch vs stall: br_taken=1 together with a load-use match -> ifid_clr=1, idex_clr=1, pc_en=1; cnt_bflush=1, cnt_stall=0.
- Jump vs stall:
  - Cycle 1: jump=1 with a load-use match -> stall outputs; cnt_jflush stays 0.
  - Cycle 2: jump=1, no match -> ifid_clr=1; cnt_jflush=1.
- Halt/resume:
  - ex_halt=1 at edge k -> out_halted=1 and all enables 0 after edge k; cnt_cycle frozen for 5 cycles.
  - in_go=1 -> idex_clr=1 for one cycle, then normal RUN outputs; out_halted=0.
- Wrap and reset:
  - CNT_W=4, 16 RUN cycles -> cnt_cycle returns to 0.
  - in_CLR_N=0 mid-HALT -> state RUN and all counters 0 without waiting for a clock edge.
